// File: rtl/dac_modified_if.sv
// Bundle of sequencer, sample, configuration and DAC-side signals for one
// analog-output channel. The controller drives it through the master
// modport. The channel consumes it through the slave modport.
interface dac_modified_if;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [15:0] DAC_input;
    logic [15:0] DAC_sequencer_in;
    logic        use_sequencer;
    logic        DAC_en;
    logic [2:0]  gain;
    logic [6:0]  noise_suppress;
    logic [15:0] DAC_thrsh;
    logic        DAC_thrsh_pol;
    logic [15:0] DAC_fsm_start_win_in;
    logic [15:0] DAC_fsm_stop_win_in;
    logic [15:0] DAC_fsm_state_counter_in;
    logic [15:0] HPF_coefficient;
    logic        HPF_en;
    logic        software_reference_mode;
    logic [15:0] software_reference;
    logic        DAC_SYNC;
    logic        DAC_SCLK;
    logic        DAC_DIN;
    logic        DAC_thrsh_out;
    logic        DAC_fsm_inwin_out;
    logic [15:0] DAC_register;

    modport master (
        output main_state, channel, DAC_input, DAC_sequencer_in, use_sequencer,
               DAC_en, gain, noise_suppress, DAC_thrsh, DAC_thrsh_pol,
               DAC_fsm_start_win_in, DAC_fsm_stop_win_in, DAC_fsm_state_counter_in,
               HPF_coefficient, HPF_en, software_reference_mode, software_reference,
        input  DAC_SYNC, DAC_SCLK, DAC_DIN, DAC_thrsh_out, DAC_fsm_inwin_out,
               DAC_register
    );

    modport slave (
        input  main_state, channel, DAC_input, DAC_sequencer_in, use_sequencer,
               DAC_en, gain, noise_suppress, DAC_thrsh, DAC_thrsh_pol,
               DAC_fsm_start_win_in, DAC_fsm_stop_win_in, DAC_fsm_state_counter_in,
               HPF_coefficient, HPF_en, software_reference_mode, software_reference,
        output DAC_SYNC, DAC_SCLK, DAC_DIN, DAC_thrsh_out, DAC_fsm_inwin_out,
               DAC_register
    );
endinterface

// File: rtl/dac_modified.sv
// One analog-output channel. Once per frame it takes a sample and applies
// reference subtraction, a first-order high-pass filter, gain and a dead
// band. It publishes the result with threshold/window flags and streams
// the result to a 16-bit SPI DAC. The SPI stream is 24 bits per frame,
// two bits per sequencer channel slot.
module dac_modified (
    input  logic          dataclk,
    input  logic          reset,
    dac_modified_if.slave bus
);
    localparam logic [31:0] ST_CLK1_A  = 32'd100;
    localparam logic [31:0] ST_CLK9_D  = 32'd135;
    localparam logic [31:0] ST_CLK18_C = 32'd170;
    localparam logic [31:0] ST_CLK27_B = 32'd205;

    // Clamp a 17-bit signed intermediate to the 16-bit signed range.
    function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
        if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7fff;
        return v[15:0];
    endfunction

    logic        sample_edge;
    logic        spi_slot;
    assign sample_edge = (bus.main_state == ST_CLK9_D) && (bus.channel == 6'd0);
    assign spi_slot    = (bus.channel < 6'd12);

    logic signed [31:0] hpf_s;
    logic [15:0]        dac_reg;
    logic               thr_q;
    logic               win_q;
    logic [23:0]        shreg;
    logic               sync_q;
    logic               sclk_q;
    logic               din_q;

    logic [15:0]        src;
    logic signed [15:0] x_raw;
    logic signed [15:0] x_ref;
    logic signed [16:0] ref_diff;
    logic signed [16:0] hpf_diff;
    logic signed [15:0] hpf_y;
    logic signed [32:0] hpf_prod;
    logic signed [31:0] hpf_next;
    logic signed [22:0] gain_sh;
    logic signed [15:0] gain_y;
    logic [16:0]        mag;
    logic signed [15:0] ns_y;
    logic [15:0]        reg_next;
    logic               thr_next;
    logic               win_next;

    // Sample datapath: source select through to the next DAC word and flags.
    always_comb begin
        src      = bus.use_sequencer ? bus.DAC_sequencer_in : bus.DAC_input;
        x_raw    = $signed(src ^ 16'h8000);
        // Offset-binary difference equals the signed difference of the two samples
        ref_diff = $signed({1'b0, src}) - $signed({1'b0, bus.software_reference});
        x_ref    = bus.software_reference_mode ? sat17(ref_diff) : x_raw;
        // The filter output is the input minus the tracked low-frequency estimate S
        hpf_diff = $signed({x_ref[15], x_ref}) - $signed({hpf_s[31], hpf_s[31:16]});
        hpf_y    = bus.HPF_en ? sat17(hpf_diff) : x_ref;
        hpf_prod = $signed({16'd0, bus.HPF_coefficient}) * $signed({{17{hpf_y[15]}}, hpf_y});
        hpf_next = bus.HPF_en ? (hpf_s + hpf_prod[31:0]) : 32'sd0;
        gain_sh  = $signed({{7{hpf_y[15]}}, hpf_y}) <<< bus.gain;
        gain_y   = (gain_sh[22:15] == {8{gain_sh[15]}}) ? gain_sh[15:0]
                 : (gain_sh[22] ? 16'sh8000 : 16'sh7fff);
        mag      = gain_y[15] ? (17'd0 - {1'b1, gain_y}) : {1'b0, gain_y};
        ns_y     = (mag <= {6'd0, bus.noise_suppress, 4'd0}) ? 16'sd0 : gain_y;
        reg_next = bus.DAC_en ? (ns_y ^ 16'h8000) : 16'h8000;
        thr_next = bus.DAC_thrsh_pol ? (reg_next >= bus.DAC_thrsh) : (reg_next <= bus.DAC_thrsh);
        win_next = thr_next
                && (bus.DAC_fsm_start_win_in <= bus.DAC_fsm_state_counter_in)
                && (bus.DAC_fsm_state_counter_in <= bus.DAC_fsm_stop_win_in);
    end

    // Commit the new sample, filter state and flags once per frame.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            hpf_s   <= '0;
            dac_reg <= 16'h8000;
            thr_q   <= 1'b0;
            win_q   <= 1'b0;
        end else if (sample_edge) begin
            hpf_s   <= hpf_next;
            dac_reg <= reg_next;
            thr_q   <= thr_next;
            win_q   <= win_next;
        end
    end

    // SPI shifter: the frame starts at channel 0 and shifts two bits per slot.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b1;
            sclk_q <= 1'b0;
            din_q  <= 1'b0;
            shreg  <= '0;
        end else begin
            case (bus.main_state)
                ST_CLK1_A: begin
                    if (bus.channel == 6'd0) begin
                        // Bit 23 (always 0) goes out now, and the rest waits in the shifter
                        sync_q <= 1'b0;
                        din_q  <= 1'b0;
                        sclk_q <= 1'b1;
                        shreg  <= {7'd0, dac_reg, 1'b0};
                    end else if (spi_slot) begin
                        din_q  <= shreg[23];
                        sclk_q <= 1'b1;
                        shreg  <= {shreg[22:0], 1'b0};
                    end else begin
                        din_q  <= 1'b0;
                        sclk_q <= 1'b0;
                        if (bus.channel == 6'd12) sync_q <= 1'b1;
                    end
                end
                ST_CLK18_C: begin
                    if (spi_slot) begin
                        din_q  <= shreg[23];
                        sclk_q <= 1'b1;
                        shreg  <= {shreg[22:0], 1'b0};
                    end else begin
                        din_q  <= 1'b0;
                        sclk_q <= 1'b0;
                    end
                end
                ST_CLK9_D, ST_CLK27_B: begin
                    sclk_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.DAC_register      = dac_reg;
    assign bus.DAC_thrsh_out     = thr_q;
    assign bus.DAC_fsm_inwin_out = win_q;
    assign bus.DAC_SYNC          = sync_q;
    assign bus.DAC_SCLK          = sclk_q;
    assign bus.DAC_DIN           = din_q;
endmodule

// File: tb/tb_dac_modified.sv
// Bench for dac_modified. It runs directed test-plan cases and then
// randomized frames. The DUT is compared against an integer-arithmetic
// model of the sample path, and the SPI bits collected on rising SCLK
// edges are compared against the expected frame.
module tb_dac_modified;
    logic dataclk = 1'b0;
    logic reset;
    always #5 dataclk = ~dataclk;

    dac_modified_if bus();
    dac_modified dut (.dataclk(dataclk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int          m_s;
    int          m_reg;
    bit          m_thr, m_win, m_sync;
    int          frame_exp;
    logic [23:0] bits, last_bits;
    int          nbits;
    bit          active;
    logic        sclk_prev;
    logic [15:0] last_reg;
    logic        last_thr, last_win;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_reset();
        m_s = 0; m_reg = 32768; m_thr = 0; m_win = 0; m_sync = 1;
        active = 0; nbits = 0; bits = '0; sclk_prev = 1'b0;
    endtask

    task automatic model_sample();
        int s, x, y;
        longint g, a;
        s = bus.use_sequencer ? int'(bus.DAC_sequencer_in) : int'(bus.DAC_input);
        if (bus.software_reference_mode) x = clamp(longint'(s) - longint'(bus.software_reference));
        else                             x = s - 32768;
        if (bus.HPF_en) begin
            y   = clamp(longint'(x) - longint'(m_s >>> 16));
            m_s = int'(longint'(m_s) + longint'(bus.HPF_coefficient) * longint'(y));
        end else begin
            y   = x;
            m_s = 0;
        end
        g = clamp(longint'(y) * (longint'(1) << bus.gain));
        a = (g < 0) ? -g : g;
        if (a <= longint'(bus.noise_suppress) * 16) g = 0;
        m_reg = bus.DAC_en ? int'(g) + 32768 : 32768;
        m_thr = bus.DAC_thrsh_pol ? (m_reg >= int'(bus.DAC_thrsh)) : (m_reg <= int'(bus.DAC_thrsh));
        m_win = m_thr && (bus.DAC_fsm_start_win_in <= bus.DAC_fsm_state_counter_in)
                      && (bus.DAC_fsm_state_counter_in <= bus.DAC_fsm_stop_win_in);
    endtask

    task automatic step(input int ch, input int st);
        bus.channel    = 6'(ch);
        bus.main_state = 32'(st);
        @(posedge dataclk); #1;
        if (st == 100 && ch == 0) begin
            frame_exp = m_reg; bits = '0; nbits = 0; active = 1; m_sync = 0;
        end
        if (st == 100 && ch == 12) m_sync = 1;
        if (st == 135 && ch == 0) begin
            model_sample();
            chk("dac_register", 32'(bus.DAC_register), 32'(m_reg));
            chk("thrsh_out", 32'(bus.DAC_thrsh_out), 32'(m_thr));
            chk("inwin_out", 32'(bus.DAC_fsm_inwin_out), 32'(m_win));
            last_reg = bus.DAC_register;
            last_thr = bus.DAC_thrsh_out;
            last_win = bus.DAC_fsm_inwin_out;
        end
        if (!sclk_prev && bus.DAC_SCLK) begin
            bits = {bits[22:0], bus.DAC_DIN};
            nbits++;
        end
        sclk_prev = bus.DAC_SCLK;
        if (st == 100 && ch == 12 && active) begin
            chk("spi_nbits", 32'(nbits), 32'd24);
            chk("spi_frame", 32'(bits), 32'(frame_exp));
            last_bits = bits;
            active = 0;
        end
        chk("sync", 32'(bus.DAC_SYNC), 32'(m_sync));
        if (ch >= 12) chk("spi_idle", {30'd0, bus.DAC_SCLK, bus.DAC_DIN}, 32'd0);
    endtask

    // One sequencer pass over channels 0..last_ch, including one unlisted state per slot.
    task automatic run_frame(input int last_ch);
        int junk;
        for (int ch = 0; ch <= last_ch; ch++) begin
            step(ch, 100);
            step(ch, 135);
            step(ch, 170);
            step(ch, 205);
            step(ch, 99);
            do junk = int'($urandom_range(0, 255));
            while (junk == 99 || junk == 100 || junk == 135 || junk == 170 || junk == 205);
            step(ch, junk);
        end
    endtask

    task automatic set_defaults();
        bus.DAC_input = 16'h8000; bus.DAC_sequencer_in = 16'h8000; bus.use_sequencer = 0;
        bus.DAC_en = 1; bus.gain = 0; bus.noise_suppress = 0;
        bus.DAC_thrsh = 16'hFFFF; bus.DAC_thrsh_pol = 1;
        bus.DAC_fsm_start_win_in = 0; bus.DAC_fsm_stop_win_in = 0; bus.DAC_fsm_state_counter_in = 1;
        bus.HPF_coefficient = 16'd3343; bus.HPF_en = 0;
        bus.software_reference_mode = 0; bus.software_reference = 16'h8000;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sync"}, 32'(bus.DAC_SYNC), 32'd1);
        chk({tag, "_sclk"}, 32'(bus.DAC_SCLK), 32'd0);
        chk({tag, "_din"},  32'(bus.DAC_DIN), 32'd0);
        chk({tag, "_thr"},  32'(bus.DAC_thrsh_out), 32'd0);
        chk({tag, "_win"},  32'(bus.DAC_fsm_inwin_out), 32'd0);
        chk({tag, "_reg"},  32'(bus.DAC_register), 32'h8000);
    endtask

    initial begin
        logic [15:0] prev;
        set_defaults();
        bus.channel = 0; bus.main_state = 32'd99;
        reset = 1'b1;
        model_reset();
        #101;
        check_reset_values("reset");
        reset = 1'b0;

        // reset release, plain pass-through
        bus.DAC_input = 16'd40000;
        run_frame(19);
        chk("pass_40000", 32'(last_reg), 32'd40000);

        bus.use_sequencer = 1; bus.DAC_sequencer_in = 16'd40000; bus.DAC_input = 16'd1000;
        run_frame(19);
        chk("seq_40000", 32'(last_reg), 32'd40000);
        bus.use_sequencer = 0;

        // HPF step response
        bus.HPF_en = 1; bus.DAC_input = 16'd42768;
        run_frame(19);
        chk("hpf_s1", 32'(last_reg), 32'd42768);
        run_frame(19);
        chk("hpf_s2", 32'(last_reg), 32'd42258);
        for (int i = 0; i < 8; i++) begin
            prev = last_reg;
            run_frame(19);
            chk("hpf_decay", 32'(last_reg < prev && last_reg >= 16'd32767), 32'd1);
        end
        bus.HPF_en = 0;

        // gain and saturation
        bus.gain = 2; bus.DAC_input = 16'd33768; run_frame(19);
        chk("gain2", 32'(last_reg), 32'd36768);
        bus.gain = 3; bus.DAC_input = 16'd50000; run_frame(19);
        chk("gain_sat_hi", 32'(last_reg), 32'd65535);
        bus.DAC_input = 16'd15000; run_frame(19);
        chk("gain_sat_lo", 32'(last_reg), 32'd0);
        bus.gain = 0;

        // noise dead band and software reference
        bus.noise_suppress = 10; bus.DAC_input = 16'd32868; run_frame(19);
        chk("noise_in", 32'(last_reg), 32'd32768);
        bus.DAC_input = 16'd32929; run_frame(19);
        chk("noise_out", 32'(last_reg), 32'd32929);
        bus.noise_suppress = 0;
        bus.software_reference_mode = 1; bus.software_reference = 16'd32900;
        bus.DAC_input = 16'd33000; run_frame(19);
        chk("sw_ref", 32'(last_reg), 32'd32868);
        bus.software_reference_mode = 0;

        // threshold and window
        bus.DAC_thrsh_pol = 0; bus.DAC_thrsh = 16'd1; bus.DAC_input = 16'd0; run_frame(19);
        chk("thr_pol0", 32'(last_thr), 32'd1);
        bus.DAC_thrsh_pol = 1; bus.DAC_thrsh = 16'd40000; bus.DAC_input = 16'd40000;
        bus.DAC_fsm_start_win_in = 0; bus.DAC_fsm_stop_win_in = 5;
        bus.DAC_fsm_state_counter_in = 3; run_frame(19);
        chk("thr_pol1", 32'(last_thr), 32'd1);
        chk("win_in", 32'(last_win), 32'd1);
        bus.DAC_fsm_state_counter_in = 6; run_frame(19);
        chk("win_out", 32'(last_win), 32'd0);
        bus.DAC_fsm_start_win_in = 5; bus.DAC_fsm_stop_win_in = 3; bus.DAC_fsm_state_counter_in = 4;
        run_frame(19);
        chk("win_inverted", 32'(last_win), 32'd0);
        set_defaults();

        // SPI content
        bus.DAC_input = 16'hA5C3; run_frame(19);
        bus.DAC_en = 0; run_frame(19);
        chk("spi_a5c3", 32'(last_bits), 32'h00A5C3);
        run_frame(19);
        chk("spi_disabled", 32'(last_bits), 32'h008000);
        bus.DAC_en = 1;

        // incomplete frame followed by a restart
        bus.DAC_input = 16'h1234; run_frame(19);
        run_frame(6);
        run_frame(19);

        // reset in the middle of a frame
        bus.DAC_input = 16'hC001; run_frame(19);
        run_frame(5);
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_values("mid_reset");
        repeat (3) @(posedge dataclk);
        #1;
        reset = 1'b0;
        run_frame(19);
        chk("post_reset_frame", 32'(last_bits), 32'h008000);
        run_frame(19);

        // randomized frames
        for (int f = 0; f < 150; f++) begin
            bus.DAC_input = 16'($urandom);
            bus.DAC_sequencer_in = 16'($urandom);
            bus.use_sequencer = 1'($urandom_range(0, 1));
            bus.DAC_en = ($urandom_range(0, 7) != 0);
            bus.gain = 3'($urandom_range(0, 3));
            bus.noise_suppress = 7'($urandom_range(0, 15));
            bus.DAC_thrsh = 16'($urandom);
            bus.DAC_thrsh_pol = 1'($urandom_range(0, 1));
            bus.DAC_fsm_start_win_in = 16'($urandom_range(0, 15));
            bus.DAC_fsm_stop_win_in = 16'($urandom_range(0, 15));
            bus.DAC_fsm_state_counter_in = 16'($urandom_range(0, 15));
            bus.HPF_coefficient = ($urandom_range(0, 1) != 0) ? 16'd3343 : 16'($urandom);
            bus.HPF_en = ($urandom_range(0, 3) != 0);
            bus.software_reference_mode = 1'($urandom_range(0, 1));
            bus.software_reference = 16'($urandom);
            run_frame(19);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dac_modified.md
# dac_modified

One analog-output channel of the acquisition controller. It processes one amplifier sample per frame:
- optional software-reference subtraction;
- first-order high-pass filter;
- gain;
- noise-suppression dead band.

It publishes the result, streams it to an external 16-bit SPI DAC, and flags threshold crossings and whether a crossing falls in the state-counter window. It runs in lockstep with the controller's `main_state`/`channel` sequencer.

## Interface
- Parameters: none.
- `dataclk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `main_state` in 32: sequencer state; uses 99 (wait), 100 (clk1_a), 135 (clk9_d), 170 (clk18_c), 205 (clk27_b).
- `channel` in 6: current sequencer channel slot, 0–19.
- `DAC_input` in 16: amplifier sample, offset binary.
- `DAC_sequencer_in` in 16: alternate source, offset binary.
- `use_sequencer` in 1: 1 selects `DAC_sequencer_in`.
- `DAC_en` in 1: 0 forces midscale output.
- `gain` in 3: left shift 0–7.
- `noise_suppress` in 7: dead-band half-width in units of 16 LSB.
- `DAC_thrsh` in 16: threshold, offset binary.
- `DAC_thrsh_pol` in 1: 1 = high when ≥ threshold; 0 = high when ≤ threshold.
- `DAC_fsm_start_win_in`, `DAC_fsm_stop_win_in`, `DAC_fsm_state_counter_in` in 16 each: window bounds and current counter.
- `HPF_coefficient` in 16: unsigned Q0.16 filter coefficient. 3343 gives 250 Hz at 30 kS/s.
- `HPF_en` in 1: enable filter.
- `software_reference_mode` in 1, `software_reference` in 16: reference subtraction enable and reference value (offset binary).
- `DAC_SYNC`, `DAC_SCLK`, `DAC_DIN` out 1 each: SPI to the DAC.
- `DAC_thrsh_out` out 1, `DAC_fsm_inwin_out` out 1: threshold flag and in-window flag.
- `DAC_register` out 16: processed sample, offset binary.

## Operation
- All processing happens on the `dataclk` edge where `main_state`==135 and `channel`==0. Steps, in order (signed values are 16-bit two's complement, x = value ^ 0x8000):
  1. Source: s = use_sequencer ? DAC_sequencer_in : DAC_input; x = s ^ 0x8000.
  2. Software reference (mode=1): x = s − software_reference (17-bit), saturated to [−32768, 32767].
  3. HPF:
     - S is a 32-bit signed Q16.16 state.
     - y = sat16(x − S[31:16]); S ← S + HPF_coefficient·y (33-bit product, sum truncated to 32 bits).
     - HPF_en=0: y = x and S ← 0.
  4. Gain: g = sat16(y <<< gain).
  5. Noise suppression: if |g| ≤ noise_suppress·16, g = 0.
  6. Output: DAC_register ← DAC_en ? g ^ 0x8000 : 16'h8000.
- Threshold: `DAC_thrsh_out` is registered on the same edge from the new DAC_register.
  - pol=1: new DAC_register ≥ DAC_thrsh (unsigned).
  - pol=0: new DAC_register ≤ DAC_thrsh (unsigned).
- Window: `DAC_fsm_inwin_out` ← new thrsh_out AND start ≤ counter ≤ stop (unsigned, inclusive). If start > stop it stays 0.
- SPI frame:
  - 24 bits: {8'h00, DAC_register}, MSB first.
  - Shift register loaded at state 100 when `channel`==0.
  - Two bits are sent per channel slot, channels 0–11:
    - state 100: DIN ← next bit, SCLK ← 1;
    - state 135: SCLK ← 0;
    - state 170: DIN ← next bit, SCLK ← 1;
    - state 205: SCLK ← 0.
  - SYNC ← 0 at state 100 of channel 0; SYNC ← 1 at state 100 of channel 12.
  - Channel 0 state 100 always restarts the frame, even if the previous frame was incomplete.
  - Outside channels 0–11, SCLK = 0 and DIN = 0.
- Unlisted `main_state` values leave all registers unchanged.

## Timing
- Reset values: DAC_SYNC=1, DAC_SCLK=0, DAC_DIN=0, DAC_thrsh_out=0, DAC_fsm_inwin_out=0, DAC_register=16'h8000, S=0, shift register 0.
- Reset during a frame aborts it immediately; the next channel-0 state-100 edge starts a clean frame.
- Latency: an input stable before the state-135 edge appears on DAC_register and both flags right after that edge, so it is valid at states 170/205.
- The SPI frame beginning at the next channel-0 state 100 carries that value.
- Configuration inputs are sampled only at their use edge. Changing them between frames is safe.

## Test plan
- **Reset:** assert reset 100 ns. Outputs hold their reset values; after release with HPF_en=0, gain=0, input 40000 → DAC_register=40000.
- **HPF step:** HPF_en=1, coeff=3343, constant input 42768 (x=10000) → DAC_register 42768 on sample 1, 42258 on sample 2, then decays monotonically toward 32768 ±1.
- **Gain and saturation:** HPF_en=0.
  - gain=2, input 33768 → 36768.
  - gain=3, input 50000 → 65535.
  - gain=3, input 15000 → 0.
- **Noise and reference:**
  - noise_suppress=10, input 32868 → 32768; input 32929 → 32929.
  - software_reference_mode=1, ref=32900, input 33000 → 32868.
- **Threshold and window:** pol=0, thrsh=1. Then pol=1, thrsh=40000, start=0, stop=5.
  - pol=0, thrsh=1, input 0 → thrsh_out=1.
  - pol=1, input 40000 → thrsh_out=1.
  - counter=3 → inwin=1; counter=6 → inwin=0.
- **SPI:** DAC_register=0xA5C3, channels cycle 0–19. SYNC is low for channels 0–11; 24 rising SCLK edges carry 0x00A5C3 MSB first on DIN; DAC_en=0 sends 0x008000.
